// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: channel ramp-state encoding and the gamma duty helper.
// The gamma helper is only used when LED_FADE_GAMMA_EN is defined.
package led_fade_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RISE = 2'd1,
      ST_ON   = 2'd2,
      ST_FALL = 2'd3
   } fade_state_e;

   // Perceptual duty: square of the level, keeping the upper half of the product.
   function automatic logic [15:0] gamma_duty(input logic [15:0] lvl, input int unsigned bits);
      logic [31:0] sq;
      logic [31:0] sh;
      sq = {16'd0, lvl} * {16'd0, lvl};
      sh = sq >> bits;
      return sh[15:0];
   endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: ramp FSM, brightness level register and registered PWM compare.
// LED_FADE_GAMMA_EN selects the squared (perceptual) duty instead of the linear one.
module led_fade_channel
   import led_fade_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                req,
   input  logic                tick,
   input  logic                bypass,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led,
   output logic                settled
);

   localparam logic [PWM_BITS-1:0] LMAX    = '1;
   localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] LMAX_M1 = LMAX - ONE;

   fade_state_e         state;
   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] duty;

`ifdef LED_FADE_GAMMA_EN
   always_comb duty = PWM_BITS'(gamma_duty(16'(level), PWM_BITS));
`else
   always_comb duty = level;
`endif

   assign settled = (state == ST_OFF) || (state == ST_ON);

   // A request change flips direction first, so a coincident tick already steps the new way.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state <= ST_OFF;
         level <= '0;
         led   <= 1'b0;
      end else begin
         led <= (level == LMAX) | (duty > pwm_cnt);
         if (bypass) begin
            level <= req ? LMAX : '0;
            state <= req ? ST_ON : ST_OFF;
         end else begin
            case (state)
               ST_OFF: begin
                  if (req) begin
                     state <= ST_RISE;
                     if (tick) level <= level + ONE;
                  end
               end
               ST_RISE: begin
                  if (!req) begin
                     if (level == '0) begin
                        state <= ST_OFF;
                     end else begin
                        if (tick) level <= level - ONE;
                        state <= (tick && level == ONE) ? ST_OFF : ST_FALL;
                     end
                  end else if (tick) begin
                     level <= level + ONE;
                     if (level == LMAX_M1) state <= ST_ON;
                  end
               end
               ST_ON: begin
                  if (!req) begin
                     state <= ST_FALL;
                     if (tick) level <= level - ONE;
                  end
               end
               ST_FALL: begin
                  if (req) begin
                     if (level == LMAX) begin
                        state <= ST_ON;
                     end else begin
                        if (tick) level <= level + ONE;
                        state <= (tick && level == LMAX_M1) ? ST_ON : ST_RISE;
                     end
                  end else if (tick) begin
                     level <= level - ONE;
                     if (level == ONE) state <= ST_OFF;
                  end
               end
               default: state <= ST_OFF;
            endcase
         end
      end
   end

endmodule

// File: rtl/led_fade_driver.sv
// LED output stage: shared PWM counter and fade prescaler driving one ramp channel per LED.
// Define LED_FADE_GAMMA_EN for a perceptual (squared) brightness curve; default is linear.
module led_fade_driver
   import led_fade_pkg::*;
#(
   parameter int unsigned NUM_LEDS = 4,
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned STEP_DIV = 24414
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic [NUM_LEDS-1:0] i_Req,
   input  logic                i_Bypass,
   output logic [NUM_LEDS-1:0] o_LED,
   output logic                o_Settled
);

   localparam int unsigned PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PS_W-1:0]     presc;
   logic                tick;
   logic [NUM_LEDS-1:0] led_vec;
   logic [NUM_LEDS-1:0] ch_settled;

   assign tick = (presc == PS_W'(STEP_DIV - 1));

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         pwm_cnt <= '0;
         presc   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         presc   <= tick ? '0 : presc + 1'b1;
      end
   end

   for (genvar n = 0; n < NUM_LEDS; n++) begin : g_ch
      led_fade_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .i_Clk   (i_Clk),
         .i_Rst_L (i_Rst_L),
         .req     (i_Req[n]),
         .tick    (tick),
         .bypass  (i_Bypass),
         .pwm_cnt (pwm_cnt),
         .led     (led_vec[n]),
         .settled (ch_settled[n])
      );
   end

   assign o_LED     = led_vec;
   assign o_Settled = &ch_settled;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (PWM_BITS=4, STEP_DIV=4, NUM_LEDS=4) against a level-based model.
// Builds with or without LED_FADE_GAMMA_EN; the model follows the same macro.
module tb_led_fade_driver;

   localparam int LMAX = 15;

   logic       clk = 1'b0;
   logic       rst_l;
   logic [3:0] req;
   logic       bypass;
   logic [3:0] led;
   logic       settled;

   int checks = 0;
   int errors = 0;

   int         m_lvl [4];
   bit         m_lreq[4];
   int         m_k;
   logic [3:0] m_led;
   logic       m_settled;

   led_fade_driver #(
      .NUM_LEDS (4),
      .PWM_BITS (4),
      .STEP_DIV (4)
   ) dut (
      .i_Clk     (clk),
      .i_Rst_L   (rst_l),
      .i_Req     (req),
      .i_Bypass  (bypass),
      .o_LED     (led),
      .o_Settled (settled)
   );

   always #5 clk = ~clk;

   function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
      return (l * l) >> 4;
`else
      return l;
`endif
   endfunction

   // Reference: levels move one step per fade tick toward the request; settled when at the requested end.
   always @(posedge clk) begin
      if (!rst_l) begin
         m_k = 0;
         m_led = '0;
         for (int n = 0; n < 4; n++) begin
            m_lvl[n] = 0;
            m_lreq[n] = 1'b0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            m_led[n] = (m_lvl[n] == LMAX) || (duty_of(m_lvl[n]) > (m_k % 16));
            if (bypass)
               m_lvl[n] = req[n] ? LMAX : 0;
            else if ((m_k % 4) == 3)
               m_lvl[n] = req[n] ? ((m_lvl[n] < LMAX) ? m_lvl[n] + 1 : LMAX)
                                 : ((m_lvl[n] > 0) ? m_lvl[n] - 1 : 0);
            m_lreq[n] = req[n];
         end
         m_k++;
      end
      m_settled = 1'b1;
      for (int n = 0; n < 4; n++)
         if (m_lreq[n] ? (m_lvl[n] != LMAX) : (m_lvl[n] != 0)) m_settled = 1'b0;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_l = 1'b0; req = 4'hF; bypass = 1'b0;
      repeat (3) begin
         step();
         checks++;
         if (led !== 4'b0000 || settled !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold led=%b settled=%b required led=0000 settled=1", led, settled);
         end
      end
      rst_l = 1'b1; req = 4'h0;
      repeat (200) begin
         step();
         checks++;
         if (led !== 4'b0000 || settled !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle led=%b settled=%b required led=0000 settled=1", led, settled);
         end
      end
   endtask

   task automatic test_rise();
      int win_cnt;
      int prev_cnt;
      win_cnt = 0; prev_cnt = 0;
      req = 4'b0001;
      for (int c = 1; c <= 80; c++) begin
         step();
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL rise_model c=%0d led=%b settled=%b required led=%b settled=%b",
                     c, led, settled, m_led, m_settled);
         end
         if (c == 1 || c == 56) begin
            checks++;
            if (settled !== 1'b0) begin
               errors++;
               $display("FAIL rise_busy c=%0d settled=%b required 0", c, settled);
            end
         end
         if (c == 64) begin
            checks++;
            if (settled !== 1'b1) begin
               errors++;
               $display("FAIL rise_done settled=%b required 1", settled);
            end
         end
         if (c > 64) begin
            checks++;
            if (led[0] !== 1'b1) begin
               errors++;
               $display("FAIL rise_full c=%0d led0=%b required 1", c, led[0]);
            end
         end
         if (led[0] === 1'b1) win_cnt++;
         if (c % 16 == 0) begin
            checks++;
            if (win_cnt < prev_cnt) begin
               errors++;
               $display("FAIL rise_monotonic c=%0d highs=%0d required >= %0d", c, win_cnt, prev_cnt);
            end
            prev_cnt = win_cnt;
            win_cnt = 0;
         end
      end
   endtask

   task automatic test_fall();
      int guard;
      guard = 0;
      req = 4'b0011;
      while (m_lvl[1] != 8 && guard < 200) begin
         step();
         guard++;
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL fall_up_model led=%b settled=%b required led=%b settled=%b",
                     led, settled, m_led, m_settled);
         end
      end
      checks++;
      if (guard >= 200) begin
         errors++;
         $display("FAIL fall_reach8 timeout level=%0d required 8", m_lvl[1]);
      end
      req = 4'b0001;
      repeat (60) begin
         step();
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL fall_down_model led=%b settled=%b required led=%b settled=%b",
                     led, settled, m_led, m_settled);
         end
      end
      repeat (32) begin
         step();
         checks++;
         if (led[1] !== 1'b0 || settled !== 1'b1) begin
            errors++;
            $display("FAIL fall_off led1=%b settled=%b required led1=0 settled=1", led[1], settled);
         end
      end
   endtask

   task automatic test_bypass();
      bypass = 1'b1; req = 4'b1010;
      step(); step();
      repeat (4) begin
         checks++;
         if (led !== 4'b1010 || settled !== 1'b1) begin
            errors++;
            $display("FAIL bypass_snap led=%b settled=%b required led=1010 settled=1", led, settled);
         end
         step();
      end
      req = 4'b0010;
      step();
      checks++;
      if (led !== 4'b1010) begin
         errors++;
         $display("FAIL bypass_lat1 led=%b required 1010", led);
      end
      step();
      checks++;
      if (led !== 4'b0010) begin
         errors++;
         $display("FAIL bypass_lat2 led=%b required 0010", led);
      end
      repeat (40) begin
         req = 4'($urandom);
         step();
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL bypass_model led=%b settled=%b required led=%b settled=%b",
                     led, settled, m_led, m_settled);
         end
      end
      bypass = 1'b0; req = 4'($urandom);
      repeat (100) begin
         step();
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL bypass_resume led=%b settled=%b required led=%b settled=%b",
                     led, settled, m_led, m_settled);
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      req = 4'b0000; bypass = 1'b0;
      repeat (70) step();
      req = 4'b0100;
      guard = 0;
      while (m_lvl[2] != 5 && guard < 100) begin
         step();
         guard++;
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL rstmid_model led=%b settled=%b required led=%b settled=%b",
                     led, settled, m_led, m_settled);
         end
      end
      checks++;
      if (guard >= 100) begin
         errors++;
         $display("FAIL rstmid_reach5 timeout level=%0d required 5", m_lvl[2]);
      end
      rst_l = 1'b0;
      step();
      checks++;
      if (led !== 4'b0000 || settled !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_clear led=%b settled=%b required led=0000 settled=1", led, settled);
      end
      rst_l = 1'b1;
      step();
      checks++;
      if (settled !== 1'b0 || led[2] !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_restart led2=%b settled=%b required led2=0 settled=0", led[2], settled);
      end
      for (int c = 2; c <= 70; c++) begin
         step();
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL rstmid_ramp c=%0d led=%b settled=%b required led=%b settled=%b",
                     c, led, settled, m_led, m_settled);
         end
      end
      checks++;
      if (led[2] !== 1'b1 || settled !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_full led2=%b settled=%b required led2=1 settled=1", led[2], settled);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            req    = 4'($urandom);
            hold   = $urandom_range(1, 90);
            bypass = ($urandom_range(0, 9) == 0);
            rst_l  = ($urandom_range(0, 30) != 0);
         end else begin
            hold--;
            rst_l = 1'b1;
         end
         step();
         checks++;
         if (led !== m_led || settled !== m_settled) begin
            errors++;
            $display("FAIL random_model c=%0d led=%b settled=%b required led=%b settled=%b",
                     c, led, settled, m_led, m_settled);
         end
      end
      rst_l = 1'b1; bypass = 1'b0;
   endtask

   initial begin
      rst_l = 1'b0; req = '0; bypass = 1'b0;
      test_reset();
      test_rise();
      test_fall();
      test_bypass();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
